// File: rtl/pipelined_legality_checker.sv
// Registered instruction legality checker placed between fetch and decode.
// Classifies each accepted instruction against the supported extensions masked
// by a runtime enable vector and delivers it PIPE_STAGES cycles later with an
// illegal flag and cause. Keeps a saturating illegal-handoff counter and the
// most recent illegal encoding (for mtval).
//
// Ports:
//   clk, rst               clock, asynchronous active-high reset
//   in_valid/in_ready      upstream handshake (in_ready is the only comb output)
//   in_instruction, in_id  raw instruction and opaque tag
//   ext_enable             runtime extension enables (sampled at accept)
//   flush                  drop all in-flight entries
//   out_valid/out_ready    downstream handshake
//   out_instruction/out_id instruction and tag, unchanged
//   out_illegal/out_cause  classification (0 legal, 1 unknown, 2 not enabled)
//   illegal_count          saturating count of illegal handoffs
//   count_clear            synchronous counter clear
//   last_illegal(_valid)   most recent illegal instruction handed off
module pipelined_legality_checker #(
    parameter int unsigned PIPE_STAGES   = 1,
    parameter int unsigned ID_W          = 4,
    parameter int unsigned COUNT_W       = 16,
    parameter logic [6:0]  EXT_SUPPORTED = 7'h7F
) (
    input  logic               clk,
    input  logic               rst,
    input  logic               in_valid,
    output logic               in_ready,
    input  logic [31:0]        in_instruction,
    input  logic [ID_W-1:0]    in_id,
    input  logic [6:0]         ext_enable,
    input  logic               flush,
    output logic               out_valid,
    input  logic               out_ready,
    output logic [31:0]        out_instruction,
    output logic [ID_W-1:0]    out_id,
    output logic               out_illegal,
    output logic [1:0]         out_cause,
    output logic [COUNT_W-1:0] illegal_count,
    input  logic               count_clear,
    output logic [31:0]        last_illegal,
    output logic               last_illegal_valid
);

    localparam int unsigned EXT_MUL    = 0;
    localparam int unsigned EXT_DIV    = 1;
    localparam int unsigned EXT_AMO    = 2;
    localparam int unsigned EXT_IFENCE = 3;
    localparam int unsigned EXT_CSR    = 4;
    localparam int unsigned EXT_MMODE  = 5;
    localparam int unsigned EXT_SMODE  = 6;

    localparam logic [1:0] CAUSE_LEGAL   = 2'd0;
    localparam logic [1:0] CAUSE_UNKNOWN = 2'd1;
    localparam logic [1:0] CAUSE_EXT_OFF = 2'd2;

    localparam logic [6:0] OPC_LOAD     = 7'b0000011;
    localparam logic [6:0] OPC_MISC_MEM = 7'b0001111;
    localparam logic [6:0] OPC_OP_IMM   = 7'b0010011;
    localparam logic [6:0] OPC_AUIPC    = 7'b0010111;
    localparam logic [6:0] OPC_STORE    = 7'b0100011;
    localparam logic [6:0] OPC_AMO      = 7'b0101111;
    localparam logic [6:0] OPC_OP       = 7'b0110011;
    localparam logic [6:0] OPC_LUI      = 7'b0110111;
    localparam logic [6:0] OPC_BRANCH   = 7'b1100011;
    localparam logic [6:0] OPC_JALR     = 7'b1100111;
    localparam logic [6:0] OPC_JAL      = 7'b1101111;
    localparam logic [6:0] OPC_SYSTEM   = 7'b1110011;
    localparam logic [6:0] OPC_CUSTOM0  = 7'b0001011;
    localparam logic [6:0] OPC_CUSTOM1  = 7'b0101011;
    localparam logic [6:0] OPC_CUSTOM2  = 7'b1011011;
    localparam logic [6:0] OPC_CUSTOM3  = 7'b1111011;

    localparam logic [31:0] INSN_ECALL  = 32'h0000_0073;
    localparam logic [31:0] INSN_EBREAK = 32'h0010_0073;
    localparam logic [31:0] INSN_MRET   = 32'h3020_0073;
    localparam logic [31:0] INSN_SRET   = 32'h1020_0073;
    localparam logic [31:0] INSN_WFI    = 32'h1050_0073;

    localparam logic [COUNT_W-1:0] COUNT_MAX = '1;

    // ------------------------------------------------------------------
    // Decode: classify the incoming word (combinational into stage 1)
    // ------------------------------------------------------------------
    logic [6:0] opc_c;
    logic [2:0] f3_c;
    logic [6:0] f7_c;
    logic       base_c;
    logic [6:0] ext_c;
    logic [6:0] ext_en_c;
    logic       dec_illegal_c;
    logic [1:0] dec_cause_c;

    assign opc_c    = in_instruction[6:0];
    assign f3_c     = in_instruction[14:12];
    assign f7_c     = in_instruction[31:25];
    assign ext_en_c = EXT_SUPPORTED & ext_enable;

    always_comb begin : decode
        base_c = 1'b0;
        ext_c  = '0;
        case (opc_c)
            OPC_LUI, OPC_AUIPC, OPC_JAL: base_c = 1'b1;
            OPC_JALR:   base_c = (f3_c == 3'b000);
            OPC_BRANCH: base_c = (f3_c != 3'b010) && (f3_c != 3'b011);
            OPC_LOAD:   base_c = f3_c inside {3'b000, 3'b001, 3'b010, 3'b100, 3'b101};
            OPC_STORE:  base_c = f3_c inside {3'b000, 3'b001, 3'b010};
            OPC_OP_IMM: begin
                case (f3_c)
                    3'b001:  base_c = (in_instruction[31:26] == 6'b000000);
                    3'b101:  base_c = (in_instruction[31:26] == 6'b000000) ||
                                      (in_instruction[31:26] == 6'b010000);
                    default: base_c = 1'b1;
                endcase
            end
            OPC_OP: begin
                if (f7_c == 7'b0000000) begin
                    base_c = 1'b1;
                end else if (f7_c == 7'b0100000) begin
                    // Only SUB and SRA use the alternate funct7
                    base_c = (f3_c == 3'b000) || (f3_c == 3'b101);
                end else if (f7_c == 7'b0000001) begin
                    if (f3_c[2]) ext_c[EXT_DIV] = 1'b1;
                    else         ext_c[EXT_MUL] = 1'b1;
                end
            end
            OPC_MISC_MEM: begin
                if (f3_c == 3'b000)      base_c = 1'b1;
                else if (f3_c == 3'b001) ext_c[EXT_IFENCE] = 1'b1;
            end
            OPC_AMO: begin
                if (f3_c == 3'b010) begin
                    case (in_instruction[31:27])
                        5'b00000, 5'b00001, 5'b00011, 5'b00100, 5'b01000,
                        5'b01100, 5'b10000, 5'b10100, 5'b11000, 5'b11100:
                            ext_c[EXT_AMO] = 1'b1;
                        // LR requires rs2 = x0
                        5'b00010: ext_c[EXT_AMO] = (in_instruction[24:20] == 5'd0);
                        default: ;
                    endcase
                end
            end
            OPC_SYSTEM: begin
                if ((f3_c != 3'b000) && (f3_c != 3'b100)) begin
                    ext_c[EXT_CSR] = 1'b1;
                end else if (in_instruction inside {INSN_ECALL, INSN_EBREAK, INSN_MRET}) begin
                    ext_c[EXT_MMODE] = 1'b1;
                end else if ((in_instruction inside {INSN_SRET, INSN_WFI}) ||
                             ((f7_c == 7'b0001001) && (in_instruction[14:0] == 15'h0073))) begin
                    // SFENCE.VMA carries free rs1/rs2; everything else is fixed
                    ext_c[EXT_SMODE] = 1'b1;
                end
            end
            OPC_CUSTOM0, OPC_CUSTOM1, OPC_CUSTOM2, OPC_CUSTOM3: base_c = 1'b1;
            default: ;
        endcase
    end

    always_comb begin : classify
        dec_illegal_c = 1'b1;
        dec_cause_c   = CAUSE_UNKNOWN;
        if (base_c) begin
            dec_illegal_c = 1'b0;
            dec_cause_c   = CAUSE_LEGAL;
        end else if (|ext_c) begin
            if (|(ext_c & ext_en_c)) begin
                dec_illegal_c = 1'b0;
                dec_cause_c   = CAUSE_LEGAL;
            end else begin
                dec_cause_c   = CAUSE_EXT_OFF;
            end
        end
    end

    // ------------------------------------------------------------------
    // Stage 1: captures the decoded instruction
    // ------------------------------------------------------------------
    logic              s1_valid_q,   s1_valid_d;
    logic [31:0]       s1_instr_q,   s1_instr_d;
    logic [ID_W-1:0]   s1_id_q,      s1_id_d;
    logic              s1_illegal_q, s1_illegal_d;
    logic [1:0]        s1_cause_q,   s1_cause_d;
    logic              s1_pop_c;
    logic              s1_load_c;
    logic              accept_c;

    assign s1_load_c = ~s1_valid_q | s1_pop_c;
    assign in_ready  = s1_load_c;
    assign accept_c  = in_valid & s1_load_c & ~flush;

    always_comb begin : s1_next
        s1_valid_d   = s1_valid_q;
        s1_instr_d   = s1_instr_q;
        s1_id_d      = s1_id_q;
        s1_illegal_d = s1_illegal_q;
        s1_cause_d   = s1_cause_q;
        if (flush) begin
            s1_valid_d = 1'b0;
        end else if (s1_load_c) begin
            s1_valid_d = in_valid;
        end
        if (accept_c) begin
            s1_instr_d   = in_instruction;
            s1_id_d      = in_id;
            s1_illegal_d = dec_illegal_c;
            s1_cause_d   = dec_cause_c;
        end
    end

    always_ff @(posedge clk or posedge rst) begin : s1_reg
        if (rst) begin
            s1_valid_q   <= 1'b0;
            s1_instr_q   <= '0;
            s1_id_q      <= '0;
            s1_illegal_q <= 1'b0;
            s1_cause_q   <= '0;
        end else begin
            s1_valid_q   <= s1_valid_d;
            s1_instr_q   <= s1_instr_d;
            s1_id_q      <= s1_id_d;
            s1_illegal_q <= s1_illegal_d;
            s1_cause_q   <= s1_cause_d;
        end
    end

    // ------------------------------------------------------------------
    // Optional stage 2: pure register slice feeding the outputs
    // ------------------------------------------------------------------
    generate
        if (PIPE_STAGES == 2) begin : g_two
            logic            s2_valid_q,   s2_valid_d;
            logic [31:0]     s2_instr_q,   s2_instr_d;
            logic [ID_W-1:0] s2_id_q,      s2_id_d;
            logic            s2_illegal_q, s2_illegal_d;
            logic [1:0]      s2_cause_q,   s2_cause_d;
            logic            s2_load_c;

            assign s2_load_c = ~s2_valid_q | out_ready;
            assign s1_pop_c  = s2_load_c;

            always_comb begin : s2_next
                s2_valid_d   = s2_valid_q;
                s2_instr_d   = s2_instr_q;
                s2_id_d      = s2_id_q;
                s2_illegal_d = s2_illegal_q;
                s2_cause_d   = s2_cause_q;
                if (flush) begin
                    s2_valid_d = 1'b0;
                end else if (s2_load_c) begin
                    s2_valid_d = s1_valid_q;
                end
                if (s2_load_c && s1_valid_q && !flush) begin
                    s2_instr_d   = s1_instr_q;
                    s2_id_d      = s1_id_q;
                    s2_illegal_d = s1_illegal_q;
                    s2_cause_d   = s1_cause_q;
                end
            end

            always_ff @(posedge clk or posedge rst) begin : s2_reg
                if (rst) begin
                    s2_valid_q   <= 1'b0;
                    s2_instr_q   <= '0;
                    s2_id_q      <= '0;
                    s2_illegal_q <= 1'b0;
                    s2_cause_q   <= '0;
                end else begin
                    s2_valid_q   <= s2_valid_d;
                    s2_instr_q   <= s2_instr_d;
                    s2_id_q      <= s2_id_d;
                    s2_illegal_q <= s2_illegal_d;
                    s2_cause_q   <= s2_cause_d;
                end
            end

            assign out_valid       = s2_valid_q;
            assign out_instruction = s2_instr_q;
            assign out_id          = s2_id_q;
            assign out_illegal     = s2_illegal_q;
            assign out_cause       = s2_cause_q;
        end else begin : g_one
            assign s1_pop_c        = out_ready;
            assign out_valid       = s1_valid_q;
            assign out_instruction = s1_instr_q;
            assign out_id          = s1_id_q;
            assign out_illegal     = s1_illegal_q;
            assign out_cause       = s1_cause_q;
        end
    endgenerate

    // ------------------------------------------------------------------
    // Illegal-handoff statistics: saturating counter and mtval capture
    // ------------------------------------------------------------------
    logic               handoff_c;
    logic [COUNT_W-1:0] count_q, count_d;
    logic [31:0]        last_q, last_d;
    logic               last_v_q, last_v_d;

    assign handoff_c = out_valid & out_ready;

    always_comb begin : stats_next
        count_d  = count_q;
        last_d   = last_q;
        last_v_d = last_v_q;
        if (handoff_c && out_illegal) begin
            if (count_q != COUNT_MAX) count_d = count_q + COUNT_W'(1);
            last_d   = out_instruction;
            last_v_d = 1'b1;
        end
        // Clear wins over a same-cycle increment
        if (count_clear) count_d = '0;
    end

    always_ff @(posedge clk or posedge rst) begin : stats_reg
        if (rst) begin
            count_q  <= '0;
            last_q   <= '0;
            last_v_q <= 1'b0;
        end else begin
            count_q  <= count_d;
            last_q   <= last_d;
            last_v_q <= last_v_d;
        end
    end

    assign illegal_count      = count_q;
    assign last_illegal       = last_q;
    assign last_illegal_valid = last_v_q;

endmodule

// File: tb/tb_pipelined_legality_checker.sv
// Directed testbench: instance A (1 stage, 16-bit counter) and instance B
// (2 stages, 2-bit counter) share stimulus; each task checks one instance.
module tb_pipelined_legality_checker;
    localparam int unsigned ID_W = 4;

    logic clk = 1'b0;
    logic rst;
    logic in_valid;
    logic [31:0] in_instruction;
    logic [ID_W-1:0] in_id;
    logic [6:0] ext_enable;
    logic flush, out_ready, count_clear;

    logic a_in_ready, a_out_valid, a_out_illegal, a_last_illegal_valid;
    logic [31:0] a_out_instruction, a_last_illegal;
    logic [ID_W-1:0] a_out_id;
    logic [1:0] a_out_cause;
    logic [15:0] a_illegal_count;

    logic b_in_ready, b_out_valid, b_out_illegal, b_last_illegal_valid;
    logic [31:0] b_out_instruction, b_last_illegal;
    logic [ID_W-1:0] b_out_id;
    logic [1:0] b_out_cause;
    logic [1:0] b_illegal_count;

    int n_tests = 0;
    int n_fail  = 0;

    // Decode vectors: instruction, enables, expected {illegal, cause}
    logic [31:0] tbl_ins [12] = '{32'h3000_2573, 32'h3000_2573, 32'h3020_0073, 32'h1050_0073,
                                  32'h1200_0073, 32'h0000_000B, 32'h1015_202F, 32'h0000_100F,
                                  32'h0000_200F, 32'h02B5_4533, 32'h0000_3003, 32'h4000_1013};
    logic [6:0]  tbl_en  [12] = '{7'h7F, 7'h6F, 7'h5F, 7'h7F, 7'h3F, 7'h00,
                                  7'h7F, 7'h77, 7'h7F, 7'h7D, 7'h7F, 7'h7F};
    logic [2:0]  tbl_exp [12] = '{3'b000, 3'b110, 3'b110, 3'b000, 3'b110, 3'b000,
                                  3'b101, 3'b110, 3'b101, 3'b110, 3'b101, 3'b101};

    pipelined_legality_checker #(.PIPE_STAGES(1), .ID_W(ID_W), .COUNT_W(16), .EXT_SUPPORTED(7'h7F)) u_a (
        .clk(clk), .rst(rst), .in_valid(in_valid), .in_ready(a_in_ready),
        .in_instruction(in_instruction), .in_id(in_id), .ext_enable(ext_enable), .flush(flush),
        .out_valid(a_out_valid), .out_ready(out_ready), .out_instruction(a_out_instruction),
        .out_id(a_out_id), .out_illegal(a_out_illegal), .out_cause(a_out_cause),
        .illegal_count(a_illegal_count), .count_clear(count_clear),
        .last_illegal(a_last_illegal), .last_illegal_valid(a_last_illegal_valid));

    pipelined_legality_checker #(.PIPE_STAGES(2), .ID_W(ID_W), .COUNT_W(2), .EXT_SUPPORTED(7'h7F)) u_b (
        .clk(clk), .rst(rst), .in_valid(in_valid), .in_ready(b_in_ready),
        .in_instruction(in_instruction), .in_id(in_id), .ext_enable(ext_enable), .flush(flush),
        .out_valid(b_out_valid), .out_ready(out_ready), .out_instruction(b_out_instruction),
        .out_id(b_out_id), .out_illegal(b_out_illegal), .out_cause(b_out_cause),
        .illegal_count(b_illegal_count), .count_clear(count_clear),
        .last_illegal(b_last_illegal), .last_illegal_valid(b_last_illegal_valid));

    always #5 clk = ~clk;

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    // Present one instruction for a single cycle
    task automatic drive_one(input logic [31:0] ins, input logic [ID_W-1:0] id);
        in_valid = 1'b1; in_instruction = ins; in_id = id;
        step();
        in_valid = 1'b0;
    endtask

    task automatic test_reset();
        rst = 1'b1; in_valid = 1'b0; in_instruction = '0; in_id = '0;
        ext_enable = 7'h7F; flush = 1'b0; out_ready = 1'b1; count_clear = 1'b0;
        repeat (2) @(posedge clk);
        #1;
        rst = 1'b0;
        #1;
        n_tests++; if ({a_out_valid, a_out_illegal, a_out_cause, a_out_instruction, a_out_id} !== '0) begin
            n_fail++; $display("FAIL reset_a_out: got v=%0b ill=%0b c=%0d ins=%h id=%h want all 0",
                               a_out_valid, a_out_illegal, a_out_cause, a_out_instruction, a_out_id); end
        n_tests++; if ({a_illegal_count, a_last_illegal, a_last_illegal_valid} !== '0) begin
            n_fail++; $display("FAIL reset_a_stats: got cnt=%0d last=%h lv=%0b want 0",
                               a_illegal_count, a_last_illegal, a_last_illegal_valid); end
        n_tests++; if (a_in_ready !== 1'b1 || b_in_ready !== 1'b1) begin
            n_fail++; $display("FAIL reset_in_ready: got a=%0b b=%0b want 1", a_in_ready, b_in_ready); end
        n_tests++; if (b_out_valid !== 1'b0 || b_illegal_count !== 2'd0) begin
            n_fail++; $display("FAIL reset_b: got v=%0b cnt=%0d want 0", b_out_valid, b_illegal_count); end
    endtask

    task automatic test_basic_stream();
        in_valid = 1'b1; in_instruction = 32'h00B5_0533; in_id = 4'h3;
        step();
        n_tests++; if ({a_out_valid, a_out_illegal, a_out_cause, a_out_instruction, a_out_id} !== {1'b1, 1'b0, 2'd0, 32'h00B5_0533, 4'h3}) begin
            n_fail++; $display("FAIL stream_add: got v=%0b ill=%0b c=%0d ins=%h id=%h want v=1 ill=0 c=0 ins=00b50533 id=3",
                               a_out_valid, a_out_illegal, a_out_cause, a_out_instruction, a_out_id); end
        in_instruction = 32'h40B5_0533; in_id = 4'h5;
        step();
        n_tests++; if ({a_out_valid, a_out_illegal, a_out_cause, a_out_instruction, a_out_id} !== {1'b1, 1'b0, 2'd0, 32'h40B5_0533, 4'h5}) begin
            n_fail++; $display("FAIL stream_sub: got v=%0b ill=%0b c=%0d ins=%h id=%h want v=1 ill=0 c=0 ins=40b50533 id=5",
                               a_out_valid, a_out_illegal, a_out_cause, a_out_instruction, a_out_id); end
        in_valid = 1'b0;
        step();
        n_tests++; if (a_out_valid !== 1'b0 || a_illegal_count !== 16'd0) begin
            n_fail++; $display("FAIL stream_drain: got v=%0b cnt=%0d want v=0 cnt=0", a_out_valid, a_illegal_count); end
    endtask

    task automatic test_ext_disable();
        ext_enable = 7'h7E;
        drive_one(32'h02B5_0533, 4'h7);
        n_tests++; if ({a_out_valid, a_out_illegal, a_out_cause} !== {1'b1, 1'b1, 2'd2}) begin
            n_fail++; $display("FAIL mul_disabled: got v=%0b ill=%0b c=%0d want v=1 ill=1 c=2",
                               a_out_valid, a_out_illegal, a_out_cause); end
        step();
        n_tests++; if ({a_illegal_count, a_last_illegal, a_last_illegal_valid} !== {16'd1, 32'h02B5_0533, 1'b1}) begin
            n_fail++; $display("FAIL mul_capture: got cnt=%0d last=%h lv=%0b want cnt=1 last=02b50533 lv=1",
                               a_illegal_count, a_last_illegal, a_last_illegal_valid); end
        ext_enable = 7'h7F;
        drive_one(32'h02B5_0533, 4'h8);
        n_tests++; if ({a_out_valid, a_out_illegal, a_out_cause} !== {1'b1, 1'b0, 2'd0}) begin
            n_fail++; $display("FAIL mul_enabled: got v=%0b ill=%0b c=%0d want v=1 ill=0 c=0",
                               a_out_valid, a_out_illegal, a_out_cause); end
        step();
        n_tests++; if (a_illegal_count !== 16'd1) begin
            n_fail++; $display("FAIL mul_enabled_count: got %0d want 1", a_illegal_count); end
    endtask

    task automatic test_count_clear();
        count_clear = 1'b1;
        step();
        count_clear = 1'b0;
        n_tests++; if ({a_illegal_count, a_last_illegal, a_last_illegal_valid} !== {16'd0, 32'h02B5_0533, 1'b1}) begin
            n_fail++; $display("FAIL count_clear: got cnt=%0d last=%h lv=%0b want cnt=0 last=02b50533 lv=1",
                               a_illegal_count, a_last_illegal, a_last_illegal_valid); end
    endtask

    task automatic test_unknown();
        in_valid = 1'b1; in_instruction = 32'h0000_0000; in_id = 4'h1;
        step();
        n_tests++; if ({a_out_valid, a_out_illegal, a_out_cause} !== {1'b1, 1'b1, 2'd1}) begin
            n_fail++; $display("FAIL unknown_zero: got v=%0b ill=%0b c=%0d want v=1 ill=1 c=1",
                               a_out_valid, a_out_illegal, a_out_cause); end
        in_instruction = 32'h80B5_0533; in_id = 4'h2;
        step();
        n_tests++; if ({a_out_valid, a_out_illegal, a_out_cause, a_out_id} !== {1'b1, 1'b1, 2'd1, 4'h2}) begin
            n_fail++; $display("FAIL unknown_f7: got v=%0b ill=%0b c=%0d id=%h want v=1 ill=1 c=1 id=2",
                               a_out_valid, a_out_illegal, a_out_cause, a_out_id); end
        in_valid = 1'b0;
        step();
        n_tests++; if ({a_illegal_count, a_last_illegal} !== {16'd2, 32'h80B5_0533}) begin
            n_fail++; $display("FAIL unknown_count: got cnt=%0d last=%h want cnt=2 last=80b50533",
                               a_illegal_count, a_last_illegal); end
    endtask

    task automatic test_decode_table();
        for (int i = 0; i < 12; i++) begin
            ext_enable = tbl_en[i];
            drive_one(tbl_ins[i], 4'(i));
            n_tests++; if ({a_out_illegal, a_out_cause} !== tbl_exp[i] || a_out_valid !== 1'b1) begin
                n_fail++; $display("FAIL decode_%0d: ins=%h en=%h got v=%0b ill=%0b c=%0d want v=1 ill=%0b c=%0d",
                                   i, tbl_ins[i], tbl_en[i], a_out_valid, a_out_illegal, a_out_cause,
                                   tbl_exp[i][2], tbl_exp[i][1:0]); end
            step();
        end
        ext_enable = 7'h7F;
    endtask

    task automatic test_latency2();
        flush = 1'b1; count_clear = 1'b1; in_valid = 1'b0; out_ready = 1'b1;
        step();
        flush = 1'b0; count_clear = 1'b0;
        drive_one(32'h00B5_0533, 4'h9);
        n_tests++; if (b_out_valid !== 1'b0) begin
            n_fail++; $display("FAIL lat2_early: got v=%0b want 0", b_out_valid); end
        step();
        n_tests++; if ({b_out_valid, b_out_illegal, b_out_instruction, b_out_id} !== {1'b1, 1'b0, 32'h00B5_0533, 4'h9}) begin
            n_fail++; $display("FAIL lat2_out: got v=%0b ill=%0b ins=%h id=%h want v=1 ill=0 ins=00b50533 id=9",
                               b_out_valid, b_out_illegal, b_out_instruction, b_out_id); end
        // Enables changed after accept must not reclassify the entry
        ext_enable = 7'h7E;
        drive_one(32'h02B5_0533, 4'hA);
        ext_enable = 7'h7F;
        step();
        n_tests++; if ({b_out_valid, b_out_illegal, b_out_cause} !== {1'b1, 1'b1, 2'd2}) begin
            n_fail++; $display("FAIL lat2_sampled_enable: got v=%0b ill=%0b c=%0d want v=1 ill=1 c=2",
                               b_out_valid, b_out_illegal, b_out_cause); end
        step();
    endtask

    task automatic test_backpressure();
        int accepts;
        accepts = 0;
        out_ready = 1'b0; in_valid = 1'b1;
        for (int k = 0; k < 5; k++) begin
            in_instruction = 32'h0000_0013 | (32'(k) << 20); in_id = 4'(k);
            #1;
            if (b_in_ready) accepts++;
            step();
        end
        in_valid = 1'b0;
        #1;
        n_tests++; if (accepts !== 2) begin
            n_fail++; $display("FAIL bp_accepts: got %0d want 2", accepts); end
        n_tests++; if (b_in_ready !== 1'b0) begin
            n_fail++; $display("FAIL bp_in_ready: got %0b want 0", b_in_ready); end
        n_tests++; if ({b_out_valid, b_out_instruction, b_out_id} !== {1'b1, 32'h0000_0013, 4'h0}) begin
            n_fail++; $display("FAIL bp_hold: got v=%0b ins=%h id=%h want v=1 ins=00000013 id=0",
                               b_out_valid, b_out_instruction, b_out_id); end
        out_ready = 1'b1;
        #1;
        n_tests++; if (b_in_ready !== 1'b1) begin
            n_fail++; $display("FAIL bp_ready_comb: got %0b want 1", b_in_ready); end
        step();
        n_tests++; if ({b_out_valid, b_out_instruction, b_out_id} !== {1'b1, 32'h0010_0013, 4'h1}) begin
            n_fail++; $display("FAIL bp_second: got v=%0b ins=%h id=%h want v=1 ins=00100013 id=1",
                               b_out_valid, b_out_instruction, b_out_id); end
        step();
        n_tests++; if (b_out_valid !== 1'b0) begin
            n_fail++; $display("FAIL bp_drain: got v=%0b want 0", b_out_valid); end
    endtask

    task automatic test_saturate();
        count_clear = 1'b1; out_ready = 1'b1;
        step();
        count_clear = 1'b0;
        in_valid = 1'b1;
        for (int k = 1; k <= 5; k++) begin
            in_instruction = 32'(k) << 7; in_id = 4'(k);
            step();
        end
        in_valid = 1'b0;
        repeat (3) step();
        n_tests++; if ({b_illegal_count, b_last_illegal} !== {2'd3, 32'h0000_0280}) begin
            n_fail++; $display("FAIL sat_count: got cnt=%0d last=%h want cnt=3 last=00000280",
                               b_illegal_count, b_last_illegal); end
        drive_one(32'h0000_0F80, 4'hC);
        for (int t = 0; t < 8; t++) begin
            if (b_out_valid) break;
            step();
        end
        n_tests++; if (b_out_valid !== 1'b1) begin
            n_fail++; $display("FAIL sat_wait: timeout, out_valid=%0b want 1", b_out_valid); end
        count_clear = 1'b1;
        step();
        count_clear = 1'b0;
        n_tests++; if ({b_illegal_count, b_last_illegal} !== {2'd0, 32'h0000_0F80}) begin
            n_fail++; $display("FAIL sat_clear_wins: got cnt=%0d last=%h want cnt=0 last=00000f80",
                               b_illegal_count, b_last_illegal); end
    endtask

    task automatic test_flush();
        logic seen;
        // Two entries stalled, flush with an input presented
        out_ready = 1'b0; in_valid = 1'b1;
        in_instruction = 32'h0000_0080; in_id = 4'h1; step();
        in_instruction = 32'h0000_0100; in_id = 4'h2; step();
        in_instruction = 32'h00B5_0533; in_id = 4'h3; flush = 1'b1; step();
        flush = 1'b0; in_valid = 1'b0;
        n_tests++; if (b_out_valid !== 1'b0 || b_illegal_count !== 2'd0) begin
            n_fail++; $display("FAIL flush_stalled: got v=%0b cnt=%0d want v=0 cnt=0", b_out_valid, b_illegal_count); end
        out_ready = 1'b1; seen = 1'b0;
        repeat (4) begin step(); if (b_out_valid) seen = 1'b1; end
        n_tests++; if (seen !== 1'b0) begin
            n_fail++; $display("FAIL flush_stalled_leak: got out_valid seen=%0b want 0", seen); end
        // Flush while a handoff is completing
        in_valid = 1'b1;
        in_instruction = 32'h0000_0080; in_id = 4'h1; step();
        in_instruction = 32'h0000_0100; in_id = 4'h2; step();
        in_instruction = 32'h0000_0180; in_id = 4'h3; flush = 1'b1;
        #1;
        n_tests++; if (b_in_ready !== 1'b1) begin
            n_fail++; $display("FAIL flush_in_ready: got %0b want 1", b_in_ready); end
        step();
        flush = 1'b0; in_valid = 1'b0;
        n_tests++; if ({b_out_valid, b_illegal_count, b_last_illegal} !== {1'b0, 2'd1, 32'h0000_0080}) begin
            n_fail++; $display("FAIL flush_handoff: got v=%0b cnt=%0d last=%h want v=0 cnt=1 last=00000080",
                               b_out_valid, b_illegal_count, b_last_illegal); end
        seen = 1'b0;
        repeat (4) begin step(); if (b_out_valid) seen = 1'b1; end
        n_tests++; if (seen !== 1'b0 || b_illegal_count !== 2'd1) begin
            n_fail++; $display("FAIL flush_handoff_leak: got seen=%0b cnt=%0d want seen=0 cnt=1", seen, b_illegal_count); end
    endtask

    task automatic test_async_reset();
        out_ready = 1'b1;
        drive_one(32'h00B5_0533, 4'h4);
        n_tests++; if (a_out_valid !== 1'b1) begin
            n_fail++; $display("FAIL areset_pre: got v=%0b want 1", a_out_valid); end
        #2;
        rst = 1'b1;
        #1;
        n_tests++; if ({a_out_valid, a_illegal_count, a_last_illegal_valid} !== {1'b0, 16'd0, 1'b0}) begin
            n_fail++; $display("FAIL areset_mid: got v=%0b cnt=%0d lv=%0b want 0",
                               a_out_valid, a_illegal_count, a_last_illegal_valid); end
        step();
        rst = 1'b0;
        step();
    endtask

    initial begin
        test_reset();
        test_basic_stream();
        test_ext_disable();
        test_count_clear();
        test_unknown();
        test_decode_table();
        test_latency2();
        test_backpressure();
        test_saturate();
        test_flush();
        test_async_reset();
        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL watchdog: simulation did not finish, got timeout want completion");
        $fatal(1);
    end

endmodule
